// File: rtl/fp_pkg.sv
// Shared types and helpers for the single-precision add/subtract sequencer.
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int EXT_W = 27;

    localparam logic [31:0]      QNAN    = 32'h7FC00000;
    localparam logic [31:0]      PINF    = 32'h7F800000;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        DONE
    } state_e;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp_t;

    function automatic fp_t fp_unpack(input logic [31:0] w);
        return fp_t'(w);
    endfunction

    function automatic logic [31:0] fp_pack(input logic s, input logic [EXP_W-1:0] e,
                                            input logic [MAN_W-1:0] m);
        return {s, e, m};
    endfunction

    // Hidden bit, fraction, then guard/round/sticky; exp=0 (zero or denormal) reads as 0.
    function automatic logic [EXT_W-1:0] fp_ext_man(input fp_t f);
        return (f.exp == '0) ? '0 : {1'b1, f.man, 3'b000};
    endfunction

endpackage

// File: rtl/fp_align_sticky.sv
// Combinational operand compare/swap and right alignment of the smaller operand
// with sticky collection of every bit shifted out.
module fp_align_sticky
    import fp_pkg::*;
(
    input  fp_t              a_i,
    input  fp_t              b_i,
    output logic             sign_x_o,
    output logic             sign_y_o,
    output logic [EXP_W-1:0] exp_x_o,
    output logic [EXT_W-1:0] man_x_o,
    output logic [EXT_W-1:0] man_y_o
);

    logic [EXT_W-1:0] man_a, man_b, man_y_raw, lost_mask;
    logic [EXP_W-1:0] exp_a, exp_b, exp_y, shift;
    logic             swap;

    // Larger magnitude becomes X; Y is shifted under it, lost bits fold into bit 0
    always_comb begin
        man_a     = fp_ext_man(a_i);
        man_b     = fp_ext_man(b_i);
        exp_a     = a_i.exp;
        exp_b     = b_i.exp;
        swap      = {exp_b, man_b} > {exp_a, man_a};
        sign_x_o  = swap ? b_i.sign : a_i.sign;
        sign_y_o  = swap ? a_i.sign : b_i.sign;
        exp_x_o   = swap ? exp_b : exp_a;
        exp_y     = swap ? exp_a : exp_b;
        man_x_o   = swap ? man_b : man_a;
        man_y_raw = swap ? man_a : man_b;
        shift     = exp_x_o - exp_y;
        lost_mask = '0;
        man_y_o   = '0;
        if (shift >= 8'(EXT_W)) begin
            man_y_o[0] = |man_y_raw;
        end else begin
            lost_mask  = (EXT_W'(1) << shift) - EXT_W'(1);
            man_y_o    = man_y_raw >> shift;
            man_y_o[0] = man_y_o[0] | (|(man_y_raw & lost_mask));
        end
    end

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle IEEE-754 single-precision add/subtract sequencer.
// Rounding: truncation by default; define FP_ADD_RNE_EN for round-to-nearest-even.
//
//   state | meaning
//   IDLE  | waiting for an operand pair, in_ready=1
//   ALIGN | compare/swap/align operands, detect NaN/Inf specials
//   ADD   | mantissa add/subtract; specials and exact zero exit to DONE
//   NORM  | left-normalize one bit per cycle, flush on underflow
//   ROUND | round, detect overflow, pack result
//   DONE  | result/flags held until out_ready
module fp_add_seq
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [2:0]  flags,
    output logic        busy
);

    state_e           state_q, state_d;
    fp_t              a_q, a_d, b_q, b_d;
    logic [EXP_W:0]   exp_q, exp_d;
    logic [EXT_W-1:0] man_q, man_d, man_y_q, man_y_d;
    logic             sign_q, sign_d, sub_q, sub_d, spec_q, spec_d;
    logic [31:0]      result_q, result_d;
    logic [2:0]       flags_q, flags_d;

    logic             al_sign_x, al_sign_y;
    logic [EXP_W-1:0] al_exp_x;
    logic [EXT_W-1:0] al_man_x, al_man_y;

    logic             a_nan, b_nan, a_snan, b_snan, a_inf, b_inf;
    logic [EXT_W:0]   sum;
    logic [EXT_W-1:0] diff;
    logic             rnd_up, rnd_inexact;
    logic [MAN_W+1:0] rnd_sum;
    logic [EXP_W:0]   rnd_exp;
    logic [MAN_W-1:0] rnd_man;

    fp_align_sticky u_align (
        .a_i      (a_q),
        .b_i      (b_q),
        .sign_x_o (al_sign_x),
        .sign_y_o (al_sign_y),
        .exp_x_o  (al_exp_x),
        .man_x_o  (al_man_x),
        .man_y_o  (al_man_y)
    );

    // Next-state and datapath updates for every FSM state
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        exp_d    = exp_q;
        man_d    = man_q;
        man_y_d  = man_y_q;
        sign_d   = sign_q;
        sub_d    = sub_q;
        spec_d   = spec_q;
        result_d = result_q;
        flags_d  = flags_q;

        a_nan  = (a_q.exp == EXP_MAX) && (a_q.man != '0);
        b_nan  = (b_q.exp == EXP_MAX) && (b_q.man != '0);
        a_snan = a_nan && !a_q.man[MAN_W-1];
        b_snan = b_nan && !b_q.man[MAN_W-1];
        a_inf  = (a_q.exp == EXP_MAX) && (a_q.man == '0);
        b_inf  = (b_q.exp == EXP_MAX) && (b_q.man == '0);

        sum  = {1'b0, man_q} + {1'b0, man_y_q};
        diff = man_q - man_y_q;

        rnd_inexact = |man_q[2:0];
`ifdef FP_ADD_RNE_EN
        rnd_up = man_q[2] & (man_q[1] | man_q[0] | man_q[3]);
`else
        rnd_up = 1'b0;
`endif
        rnd_sum = {1'b0, man_q[EXT_W-1:3]} + (MAN_W+2)'(rnd_up);
        rnd_exp = exp_q + (EXP_W+1)'(rnd_sum[MAN_W+1]);
        rnd_man = rnd_sum[MAN_W+1] ? rnd_sum[MAN_W:1] : rnd_sum[MAN_W-1:0];

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = fp_unpack(a);
                    b_d     = fp_unpack({b[31] ^ op, b[30:0]});
                    flags_d = '0;
                    spec_d  = 1'b0;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                exp_d   = {1'b0, al_exp_x};
                man_d   = al_man_x;
                man_y_d = al_man_y;
                sign_d  = al_sign_x;
                sub_d   = al_sign_x ^ al_sign_y;
                if (a_nan || b_nan) begin
                    result_d   = QNAN;
                    flags_d[2] = a_snan | b_snan;
                    spec_d     = 1'b1;
                end else if (a_inf && b_inf && (a_q.sign != b_q.sign)) begin
                    result_d   = QNAN;
                    flags_d[2] = 1'b1;
                    spec_d     = 1'b1;
                end else if (a_inf) begin
                    result_d = {a_q.sign, PINF[30:0]};
                    spec_d   = 1'b1;
                end else if (b_inf) begin
                    result_d = {b_q.sign, PINF[30:0]};
                    spec_d   = 1'b1;
                end
                state_d = ADD;
            end
            ADD: begin
                // Specials leave through here so they share the exact-zero latency
                if (spec_q) begin
                    state_d = DONE;
                end else if (!sub_q) begin
                    if (sum[EXT_W]) begin
                        man_d = {sum[EXT_W:2], sum[1] | sum[0]};
                        exp_d = exp_q + 9'd1;
                    end else begin
                        man_d = sum[EXT_W-1:0];
                    end
                    state_d = NORM;
                end else if (diff == '0) begin
                    result_d = '0;
                    state_d  = DONE;
                end else begin
                    man_d   = diff;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (man_q[EXT_W-1]) begin
                    state_d = ROUND;
                end else if (exp_q <= 9'd1) begin
                    // Result below the normal range (or a true zero sum): signed zero
                    result_d   = {sign_q, 31'd0};
                    flags_d[0] = flags_q[0] | (|man_q);
                    state_d    = DONE;
                end else begin
                    man_d = man_q << 1;
                    exp_d = exp_q - 9'd1;
                end
            end
            ROUND: begin
                if (rnd_exp >= 9'd255) begin
                    result_d   = {sign_q, PINF[30:0]};
                    flags_d[1] = 1'b1;
                    flags_d[0] = 1'b1;
                end else begin
                    result_d   = fp_pack(sign_q, rnd_exp[EXP_W-1:0], rnd_man);
                    flags_d[0] = flags_q[0] | rnd_inexact;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            exp_q    <= '0;
            man_q    <= '0;
            man_y_q  <= '0;
            sign_q   <= 1'b0;
            sub_q    <= 1'b0;
            spec_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            exp_q    <= exp_d;
            man_q    <= man_d;
            man_y_q  <= man_y_d;
            sign_q   <= sign_d;
            sub_q    <= sub_d;
            spec_q   <= spec_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp_add_seq.sv
// Bench for fp_add_seq: directed vector table, hand-written backpressure/reset
// sequence, and random operands against an exact big-integer reference model.
module tb_fp_add_seq;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, op, out_valid, out_ready, busy;
    logic [31:0] a, b, result;
    logic [2:0]  flags;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp_add_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic        vop;
        logic [31:0] res;
        logic [2:0]  flg;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Value of a finite operand as an integer count of 2^-149 units (denormals read as 0)
    function automatic logic [299:0] mag(input logic [31:0] x);
        int e;
        logic [299:0] m;
        e = int'(x[30:23]);
        if (e == 0) return '0;
        m = (300'(1) << 23) | 300'(x[22:0]);
        return m << (e - 1);
    endfunction

    // Reference: exact sum, then truncate (or RNE), flush tiny results, saturate to Inf
    function automatic void ref_add(input logic [31:0] x, input logic [31:0] y, input logic opv,
                                    output logic [31:0] r, output logic [2:0] f);
        logic sa, sb, s, xnan, ynan, xinf, yinf, inexact;
        logic [299:0] va, vb, m, rem, half;
        logic [24:0] mm;
        int p, e, sh;
        sa = x[31];
        sb = y[31] ^ opv;
        f  = 3'b000;
        xnan = (x[30:23] == 8'hFF) && (x[22:0] != 0);
        ynan = (y[30:23] == 8'hFF) && (y[22:0] != 0);
        xinf = (x[30:23] == 8'hFF) && (x[22:0] == 0);
        yinf = (y[30:23] == 8'hFF) && (y[22:0] == 0);
        if (xnan || ynan) begin
            r    = 32'h7FC00000;
            f[2] = (xnan && !x[22]) || (ynan && !y[22]);
            return;
        end
        if (xinf && yinf && sa != sb) begin
            r = 32'h7FC00000;
            f = 3'b100;
            return;
        end
        if (xinf) begin r = {sa, 31'h7F800000}; return; end
        if (yinf) begin r = {sb, 31'h7F800000}; return; end
        va = mag(x);
        vb = mag(y);
        if (sa == sb)      begin m = va + vb; s = sa; end
        else if (va >= vb) begin m = va - vb; s = sa; end
        else               begin m = vb - va; s = sb; end
        if (m == 0) begin
            r = (sa != sb) ? 32'h0 : {sa, 31'h0};
            return;
        end
        p = -1;
        for (int i = 0; i < 300; i++) if (m[i]) p = i;
        if (p < 23) begin
            r = {s, 31'h0};
            f = 3'b001;
            return;
        end
        e   = p - 22;
        sh  = p - 23;
        mm  = 25'(m >> sh);
        rem = m & ((300'(1) << sh) - 300'(1));
        inexact = (rem != 0);
`ifdef FP_ADD_RNE_EN
        if (sh > 0) begin
            half = 300'(1) << (sh - 1);
            if (rem > half || (rem == half && mm[0])) mm = mm + 25'd1;
            if (mm[24]) begin mm = mm >> 1; e = e + 1; end
        end
`else
        half = '0;
`endif
        if (e >= 255) begin
            r = {s, 31'h7F800000};
            f = 3'b011;
        end else begin
            r    = {s, 8'(e), mm[22:0]};
            f[0] = inexact;
        end
    endfunction

    // Issue one operand pair and wait for DONE; leaves the DUT in DONE
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic opv,
                          output int lat, output logic rdy_e0, output logic busy_e0);
        @(negedge clk);
        a = av; b = bv; op = opv; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rdy_e0   = in_ready;
        busy_e0  = busy;
        lat      = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: out_valid never rose for a=%h b=%h op=%0d", av, bv, opv);
        end
    endtask

    task automatic accept_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] rand_a();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 9))
            0: begin v[30:23] = 8'hFF; if ($urandom_range(0, 1) == 1) v[22:0] = '0; end
            1: v[30:23] = 8'h00;
            2: v[30:23] = 8'($urandom_range(250, 254));
            3: v[30:23] = 8'($urandom_range(1, 4));
            default: if (v[30:23] == 8'hFF) v[30:23] = 8'hFE;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] rand_b(input logic [31:0] av);
        logic [31:0] v;
        int e;
        v = $urandom;
        case ($urandom_range(0, 9))
            0: begin v[30:23] = 8'hFF; if ($urandom_range(0, 1) == 1) v[22:0] = '0; end
            1, 2, 3, 4: v[30:0] = av[30:0] ^ (31'($urandom) >> $urandom_range(8, 30));
            5, 6: begin
                e = int'(av[30:23]) + $urandom_range(0, 6) - 3;
                if (e < 1) e = 1;
                if (e > 254) e = 254;
                v[30:23] = 8'(e);
            end
            default: if (v[30:23] == 8'hFF) v[30:23] = 8'hFE;
        endcase
        return v;
    endfunction

    vec_t vecs[5];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic rdy_e0, busy_e0;
        logic [31:0] er;
        logic [2:0]  ef;

        vecs[0] = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 4};
        vecs[1] = '{32'h40400000, 32'h40300000, 1'b1, 32'h3E800000, 3'b000, 7};
        vecs[2] = '{32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 3'b001, 4};
        vecs[3] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011, 4};
        vecs[4] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100, 2};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset result", result, 32'h0);
        check("reset flags", 32'(flags), 32'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vop, lat, rdy_e0, busy_e0);
            check($sformatf("vec%0d in_ready after accept", i), 32'(rdy_e0), 32'd0);
            check($sformatf("vec%0d busy after accept", i), 32'(busy_e0), 32'd1);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d result", i), result, vecs[i].res);
            check($sformatf("vec%0d flags", i), 32'(flags), 32'(vecs[i].flg));
            accept_out();
            check($sformatf("vec%0d in_ready after accept_out", i), 32'(in_ready), 32'd1);
            check($sformatf("vec%0d out_valid after accept_out", i), 32'(out_valid), 32'd0);
        end

        // Backpressure: DONE holds with out_ready low; a new in_valid is ignored
        run_op(32'h3F800000, 32'h3F800000, 1'b0, lat, rdy_e0, busy_e0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 32'h40A00000; b = 32'h40A00000;
            check($sformatf("hold%0d result", c), result, 32'h40000000);
            check($sformatf("hold%0d in_ready", c), 32'(in_ready), 32'd0);
            check($sformatf("hold%0d out_valid", c), 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        accept_out();

        // Reset while normalizing 3.0-2.75 (NORM spans E2..E6)
        @(negedge clk);
        a = 32'h40400000; b = 32'h40300000; op = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid-op busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst mid-op in_ready", 32'(in_ready), 32'd1);
        check("rst mid-op out_valid", 32'(out_valid), 32'd0);
        check("rst mid-op flags", 32'(flags), 32'd0);
        check("rst mid-op result", result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("post-rst idle%0d out_valid", c), 32'(out_valid), 32'd0);
        end

        // Random operands against the reference model
        for (int t = 0; t < 300; t++) begin
            logic [31:0] ra, rb;
            logic        rop;
            ra  = rand_a();
            rb  = rand_b(ra);
            rop = 1'($urandom_range(0, 1));
            ref_add(ra, rb, rop, er, ef);
            run_op(ra, rb, rop, lat, rdy_e0, busy_e0);
            check($sformatf("rand%0d result a=%h b=%h op=%0d", t, ra, rb, rop), result, er);
            check($sformatf("rand%0d flags a=%h b=%h op=%0d", t, ra, rb, rop), 32'(flags), 32'(ef));
            accept_out();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
